// File: rtl/sr_seq_pkg.sv
// Shared types for the rotating shift-register sequencer.
// Holds the controller state encoding and rotation direction constants.
package sr_seq_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  localparam logic DIR_LEFT  = 1'b0;
  localparam logic DIR_RIGHT = 1'b1;

  function automatic logic [7:0] rot8(
    input logic [7:0] d,
    input logic       dir
  );
    logic [7:0] r;
    if (dir == DIR_RIGHT) r = {d[0], d[7:1]};
    else                  r = {d[6:0], d[7]};
    return r;
  endfunction

endpackage

// File: rtl/sr_seq_tick.sv
// Free-running N-bit divider; tick is high while the count is all-ones,
// so the edge it qualifies is the wrap back to zero.
module tick_gen #(
  parameter int N = 20
) (
  input  logic clk,
  input  logic rstn,
  output logic tick
);

  logic [N-1:0] cnt_q;
  logic [N-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q + N'(1);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign tick = &cnt_q;

endmodule

// File: rtl/sr_seq.sv
// Rotating 8-bit register sequencer: loads a pattern on start and rotates
// it once per divider tick for a counted or unbounded number of steps.
module sr_seq
  import sr_seq_pkg::*;
#(
  parameter int         N   = 20,
  parameter logic [7:0] DIN = 8'h07
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       start,
  input  logic       stop,
  input  logic       dir,
  input  logic [7:0] pattern,
  input  logic [7:0] steps,
  output logic [7:0] data,
  output logic       busy,
  output logic       done
);

  logic tick;

  tick_gen #(.N(N)) u_tick (
    .clk  (clk),
    .rstn (rstn),
    .tick (tick)
  );

  state_e     state_q, state_d;
  logic [7:0] data_q, data_d;
  logic [7:0] rem_q, rem_d;
  logic       dir_q, dir_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    rem_d   = rem_q;
    dir_d   = dir_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          data_d  = pattern;
          rem_d   = steps;
          dir_d   = dir;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        // stop wins over a coincident tick
        if (stop) begin
          state_d = S_IDLE;
        end else if (tick) begin
          data_d = rot8(data_q, dir_q);
          if (rem_q != 8'd0) begin
            rem_d = rem_q - 8'd1;
            if (rem_q == 8'd1) state_d = S_DONE;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    busy_d = (state_d == S_RUN);
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= S_IDLE;
      data_q  <= DIN;
      rem_q   <= 8'd0;
      dir_q   <= DIR_LEFT;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      rem_q   <= rem_d;
      dir_q   <= dir_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign data = data_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_sr_seq.sv
// Randomized self-checking bench for sr_seq with a 4-cycle tick.
// Reference model tracks mode, remaining count and cycle phase.
module tb_sr_seq;

  logic       clk = 1'b0;
  logic       rstn;
  logic       start;
  logic       stop;
  logic       dir;
  logic [7:0] pattern;
  logic [7:0] steps;
  logic [7:0] data;
  logic       busy;
  logic       done;

  sr_seq #(.N(2), .DIN(8'h07)) dut (
    .clk     (clk),
    .rstn    (rstn),
    .start   (start),
    .stop    (stop),
    .dir     (dir),
    .pattern (pattern),
    .steps   (steps),
    .data    (data),
    .busy    (busy),
    .done    (done)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // model: 0 idle, 1 run, 2 done
  int       m_mode;
  int       m_rem;
  int       m_dir;
  int       m_data;
  int       cyc;

  task automatic model_reset();
    m_mode = 0;
    m_rem  = 0;
    m_dir  = 0;
    m_data = 8'h07;
    cyc    = 0;
  endtask

  // one clock edge; model consumes the inputs present at the edge
  task automatic cycle();
    bit t;
    @(posedge clk);
    t = (cyc % 4 == 3);
    case (m_mode)
      0: if (start) begin
        m_data = pattern;
        m_rem  = steps;
        m_dir  = dir;
        m_mode = 1;
      end
      1: if (stop) m_mode = 0;
         else if (t) begin
           if (m_dir == 1) m_data = ((m_data >> 1) | (m_data << 7)) & 255;
           else            m_data = ((m_data << 1) | (m_data >> 7)) & 255;
           if (m_rem > 0) begin
             m_rem = m_rem - 1;
             if (m_rem == 0) m_mode = 2;
           end
         end
      default: m_mode = 0;
    endcase
    cyc = cyc + 1;
    #1;
  endtask

  task automatic cmp_all(input string tag);
    n_vec++;
    if (data !== 8'(m_data) || busy !== (m_mode == 1)
        || done !== (m_mode == 2)) begin
      n_err++;
      $display("FAIL %s t=%0t data=%h busy=%b done=%b exp %h %0d %0d",
               tag, $time, data, busy, done, m_data,
               m_mode == 1, m_mode == 2);
    end
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    start = 0; stop = 0; dir = 0; pattern = 0; steps = 0;
    repeat (2) @(posedge clk);
    #1;
    n_vec++;
    if (data !== 8'h07 || busy !== 1'b0 || done !== 1'b0) begin
      n_err++;
      $display("FAIL reset_state data=%h busy=%b done=%b exp 07 0 0",
               data, busy, done);
    end
    rstn = 1'b1;
    model_reset();
    for (int i = 0; i < 20; i++) begin
      cycle();
      n_vec++;
      if (data !== 8'h07 || busy !== 1'b0 || done !== 1'b0) begin
        n_err++;
        $display("FAIL idle_hold cyc=%0d data=%h busy=%b done=%b exp 07 0 0",
                 i, data, busy, done);
      end
    end
  endtask

  task automatic test_counted();
    logic [7:0] seen[$];
    logic [7:0] prev;
    int dones = 0;
    int k;
    start = 1; pattern = 8'h81; dir = 0; steps = 8'd3;
    cycle();
    start = 0;
    cmp_all("counted_load");
    prev = data;
    seen.push_back(data);
    k = 0;
    while (!(m_mode == 0) && k < 40) begin
      cycle();
      cmp_all("counted_run");
      if (done === 1'b1) dones++;
      if (data !== prev) begin
        seen.push_back(data);
        prev = data;
      end
      k++;
    end
    n_vec++;
    if (k >= 40) begin
      n_err++;
      $display("FAIL counted_timeout cycles=%0d exp <40", k);
    end
    n_vec++;
    if (seen.size() != 4 || seen[0] !== 8'h81 || seen[1] !== 8'h03
        || seen[2] !== 8'h06 || seen[3] !== 8'h0C) begin
      n_err++;
      $display("FAIL counted_seq got %p exp 81 03 06 0c", seen);
    end
    n_vec++;
    if (dones != 1) begin
      n_err++;
      $display("FAIL counted_done pulses=%0d exp 1", dones);
    end
    repeat (6) begin
      cycle();
      n_vec++;
      if (data !== 8'h0C || busy !== 1'b0) begin
        n_err++;
        $display("FAIL counted_hold data=%h busy=%b exp 0c 0", data, busy);
      end
    end
  endtask

  task automatic test_continuous();
    logic [7:0] held;
    int ticks = 0;
    start = 1; pattern = 8'h01; dir = 1; steps = 8'd0;
    cycle();
    start = 0;
    cmp_all("cont_load");
    for (int i = 0; i < 48; i++) begin
      if (cyc % 4 == 3) ticks++;
      cycle();
      cmp_all("cont_run");
    end
    n_vec++;
    if (busy !== 1'b1 || ticks <= 10) begin
      n_err++;
      $display("FAIL cont_alive busy=%b ticks=%0d exp 1 >10", busy, ticks);
    end
    while (cyc % 4 == 3) begin
      cycle();
      cmp_all("cont_align");
    end
    held = data;
    stop = 1;
    cycle();
    stop = 0;
    cmp_all("cont_stop");
    n_vec++;
    if (busy !== 1'b0 || done !== 1'b0 || data !== held) begin
      n_err++;
      $display("FAIL cont_stop_state busy=%b done=%b data=%h exp 0 0 %h",
               busy, done, data, held);
    end
  endtask

  task automatic test_stop_on_tick();
    logic [7:0] held;
    int k = 0;
    start = 1; pattern = 8'($urandom); dir = 1'($urandom); steps = 0;
    cycle();
    start = 0;
    cycle();
    while (!(m_mode == 1 && cyc % 4 == 3) && k < 10) begin
      cycle();
      k++;
    end
    held = data;
    stop = 1;
    cycle();
    stop = 0;
    n_vec++;
    if (data !== held || busy !== 1'b0 || done !== 1'b0 || k >= 10) begin
      n_err++;
      $display("FAIL stop_on_tick data=%h busy=%b done=%b exp %h 0 0",
               data, busy, done, held);
    end
    cmp_all("stop_on_tick_model");
  endtask

  task automatic test_ignore_start();
    int k = 0;
    int i = 0;
    start = 1; pattern = 8'($urandom_range(1, 254));
    dir = 1'($urandom); steps = 8'd5;
    cycle();
    start = 0;
    cmp_all("ign_load");
    while (m_mode != 0 && k < 60) begin
      start = (m_mode != 0 && i >= 2);
      pattern = 8'hFF;
      steps = 8'd1;
      cycle();
      cmp_all("ign_run");
      i++;
      k++;
    end
    start = 0;
    n_vec++;
    if (k >= 60 || data === 8'hFF) begin
      n_err++;
      $display("FAIL ign_start cycles=%0d data=%h exp <60 not ff", k, data);
    end
  endtask

  task automatic test_reset_mid();
    start = 1; pattern = 8'h3C; dir = 0; steps = 8'd0;
    cycle();
    start = 0;
    repeat (6) cycle();
    rstn = 1'b0;
    #1;
    n_vec++;
    if (data !== 8'h07 || busy !== 1'b0 || done !== 1'b0) begin
      n_err++;
      $display("FAIL async_reset data=%h busy=%b done=%b exp 07 0 0",
               data, busy, done);
    end
    #1;
    rstn = 1'b1;
    model_reset();
    start = 1; pattern = 8'hA5; dir = 1; steps = 8'd2;
    cycle();
    start = 0;
    n_vec++;
    if (data !== 8'hA5 || busy !== 1'b1) begin
      n_err++;
      $display("FAIL post_reset_start data=%h busy=%b exp a5 1", data, busy);
    end
    for (int i = 0; i < 16; i++) begin
      cycle();
      cmp_all("post_reset_run");
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      start   = ($urandom_range(0, 3) == 0);
      stop    = ($urandom_range(0, 15) == 0);
      dir     = 1'($urandom);
      pattern = 8'($urandom);
      steps   = 8'($urandom_range(0, 6));
      cycle();
      cmp_all("random");
    end
    start = 0;
    stop  = 0;
  endtask

  initial begin
    test_reset();
    test_counted();
    test_continuous();
    test_stop_on_tick();
    test_ignore_start();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
